digit_tube_ctrl: RTL and testbench
==================================

# digit_tube_ctrl

- Memory-mapped output peripheral: the processor writes a 32-bit value over the bridge, and the block drives an 8-digit, multiplexed, common-anode 7-segment display in hexadecimal.
- It sits on the same device bridge as the key-input peripheral, but carries data the other way: processor stores become display output.
- It also supports per-digit blanking and registered read-back of its registers.

## Interface

Parameters:
- SCAN_DIV, default 50000: clk cycles each digit stays lit; legal range ≥ 1.

Ports (reset is synchronous, active-high; clock is clk):
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- we  input  1  write strobe from bridge
- addr  input  1  register select: 0 = DATA, 1 = BLANK
- byte_en  input  4  byte enables for writes; bit i covers wdata[8i+7:8i]
- wdata  input  32  write data
- RD  output  32  registered read-back of the selected register
- digit_sel  output  8  digit enable, active-low, one-hot; bit i selects digit i
- seg  output  8  segment drive, active-low; seg[7] = dp, seg[6:0] = g..a

## Operation

Registers:
- DATA[31:0]: digit i shows nibble DATA[4i+3:4i].
- BLANK[7:0]: when BLANK[i] = 1, digit i is dark.

Writes:
- On a clk edge with we = 1, each enabled byte of the addressed register is updated.
- BLANK uses only byte_en[0] and wdata[7:0]; other bytes are ignored.

Read-back:
- Every cycle, RD <= (addr ? {24'd0, BLANK} : DATA), sampled before any same-edge write.

Scan:
- A counter runs 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index idx (3 bits) increments mod 8, wrapping 7 -> 0.
- Writes never disturb the counter or idx.

Outputs (registered every cycle):
- digit_sel <= ~(8'b1 << idx).
- seg <= BLANK[idx] ? 8'hFF : {1'b1, hex7(DATA nibble idx)}. The decimal point is always off.
- hex7 codes (active-low, with dp included): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

## Timing

Reset values:
- DATA = 0, BLANK = 0, counter = 0, idx = 0.
- RD = 0, digit_sel = 8'hFE, seg = 8'hC0.

Latencies:
- Write at edge N changes the register at N. RD and seg reflect the new value at edge N+1.
- Write and read of the same address in the same cycle: RD returns the old value that cycle and the new value the next cycle.
- digit_sel/seg change one cycle after idx advances. Each digit is shown for exactly SCAN_DIV cycles; a full frame is 8·SCAN_DIV cycles.
- SCAN_DIV = 1: idx advances every cycle.

Boundary conditions:
- we with byte_en = 0: no register change.
- Reset asserted mid-scan or mid-write: reset wins; all state returns to reset values on that edge.

## Structure

Shared package holds:
- Register offsets ADDR_DATA = 0 and ADDR_BLANK = 1.
- The 16-entry hex-to-segment constant table.
- SEG_OFF = 8'hFF.

Sub-module:
- hex_to_seg7: purely combinational, 4-bit nibble in, 7-bit active-low segments out.

Top level holds:
- The registers.
- The scan counter and idx.
- The output registers.

## Test plan

1. Reset, then idle 8·SCAN_DIV cycles with SCAN_DIV = 4 -> digit_sel steps FE, FD, FB, … 7F, FE, each held 4 cycles; seg = C0 throughout.
2. Write DATA = 32'h89ABCDEF with byte_en = 4'hF -> digits 0..7 show 8E, 86, A1, C6, 83, 88, 90, 80 in scan order; RD = 89ABCDEF one cycle after addr = 0.
3. Write DATA with byte_en = 4'b0010 and wdata = 32'hFFFF12FF over DATA = 0 -> DATA = 32'h00001200; digits 2/3 show A4/F9, all others C0.
4. Write BLANK = 8'hF0 (wdata upper bytes nonzero) -> digits 4..7 output seg = FF; RD at addr = 1 reads 32'h000000F0.
5. Assert reset for one cycle mid-frame at idx = 5 with nonzero DATA/BLANK -> next cycle digit_sel = FE, seg = C0, RD = 0; scan restarts from digit 0.

Source files
------------

// File: rtl/digit_tube_ctrl_pkg.sv
// Shared constants for the 8-digit hex display peripheral: register offsets,
// the active-low hex segment table and the blanked-digit pattern.
package digit_tube_ctrl_pkg;

    localparam logic ADDR_DATA  = 1'b0;
    localparam logic ADDR_BLANK = 1'b1;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Segments g..a, active-low; entry n is the glyph for hex digit n.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/digit_tube_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
module hex_to_seg7
    import digit_tube_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/digit_tube_ctrl.sv
// Memory-mapped 8-digit multiplexed common-anode hex display driver with
// per-digit blanking and registered register read-back.
module digit_tube_ctrl
    import digit_tube_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] RD,
    output logic [7:0]  digit_sel,
    output logic [7:0]  seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q, data_d;
    logic [7:0]       blank_q, blank_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      rd_q, rd_d;
    logic [7:0]       digit_sel_q, digit_sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg7;

    logic data_wr;
    logic blank_wr;

    assign data_wr  = we && (addr == ADDR_DATA);
    assign blank_wr = we && (addr == ADDR_BLANK) && byte_en[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_data_lane
            assign data_d[8*gi +: 8] = (data_wr && byte_en[gi]) ? wdata[8*gi +: 8]
                                                                : data_q[8*gi +: 8];
        end
    endgenerate

    assign blank_d = blank_wr ? wdata[7:0] : blank_q;

    // The scan runs free of bus traffic; writes only touch DATA/BLANK.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nibble),
        .seg_n_o  (cur_seg7)
    );

    // Outputs sample pre-edge state, so new writes appear one cycle later.
    assign rd_d        = (addr == ADDR_BLANK) ? {24'd0, blank_q} : data_q;
    assign digit_sel_d = ~(8'b1 << idx_q);
    assign seg_d       = blank_q[idx_q] ? SEG_OFF : {1'b1, cur_seg7};

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= '0;
            blank_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            digit_sel_q <= 8'hFE;
            seg_q       <= 8'hC0;
        end else begin
            data_q      <= data_d;
            blank_q     <= blank_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign RD        = rd_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_digit_tube_ctrl.sv
// Self-checking bench for digit_tube_ctrl: directed test-plan steps followed by
// random bus traffic, compared every cycle against a time-based reference model.
module tb_digit_tube_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] RD;
    logic [7:0]  digit_sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    // Reference model state: registers as the processor sees them, and the
    // number of clock edges since the last reset edge.
    logic [31:0] m_data;
    logic [7:0]  m_blank;
    int          m_k;
    logic [7:0]  hex_tab [16];

    digit_tube_ctrl #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .byte_en   (byte_en),
        .wdata     (wdata),
        .RD        (RD),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, m_k, obs, exp_v);
        end
    endtask

    // One bus cycle: drive inputs, clock, then compare all outputs.
    task automatic step(input logic rst, input logic w, input logic a,
                        input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] e_rd;
        logic [7:0]  e_ds;
        logic [7:0]  e_seg;
        int          shown;
        @(negedge clk);
        reset   = rst;
        we      = w;
        addr    = a;
        byte_en = be;
        wdata   = wd;
        if (rst) begin
            e_rd  = 32'd0;
            e_ds  = 8'hFE;
            e_seg = 8'hC0;
        end else begin
            shown = (m_k / SD) % 8;
            e_rd  = a ? {24'd0, m_blank} : m_data;
            e_ds  = 8'hFF - 8'(1 << shown);
            e_seg = m_blank[shown] ? 8'hFF : hex_tab[(m_data >> (4 * shown)) & 32'hF];
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_data  = 32'd0;
            m_blank = 8'd0;
            m_k     = 0;
        end else begin
            if (w && !a) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_data[8*b +: 8] = wd[8*b +: 8];
            end
            if (w && a && be[0]) m_blank = wd[7:0];
            m_k++;
        end
        check("RD", RD, e_rd);
        check("digit_sel", {24'd0, digit_sel}, {24'd0, e_ds});
        check("seg", {24'd0, seg}, {24'd0, e_seg});
        $display("step rst=%0b we=%0b addr=%0b be=%h wd=%h -> RD=%h sel=%h seg=%h",
                 rst, w, a, be, wd, RD, digit_sel, seg);
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 4'h0, 32'h0);
    endtask

    initial begin
        hex_tab[0]  = 8'hC0; hex_tab[1]  = 8'hF9; hex_tab[2]  = 8'hA4; hex_tab[3]  = 8'hB0;
        hex_tab[4]  = 8'h99; hex_tab[5]  = 8'h92; hex_tab[6]  = 8'h82; hex_tab[7]  = 8'hF8;
        hex_tab[8]  = 8'h80; hex_tab[9]  = 8'h90; hex_tab[10] = 8'h88; hex_tab[11] = 8'h83;
        hex_tab[12] = 8'hC6; hex_tab[13] = 8'hA1; hex_tab[14] = 8'h86; hex_tab[15] = 8'h8E;
        m_data  = 32'd0;
        m_blank = 8'd0;
        m_k     = 0;
        reset   = 1'b1;
        we      = 1'b0;
        addr    = 1'b0;
        byte_en = 4'h0;
        wdata   = 32'h0;

        // Reset, then one full idle frame plus a wrap.
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(8 * SD + 2, 1'b0);

        // Full DATA write, read back and watch a frame.
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h89ABCDEF);
        idle(8 * SD + 1, 1'b0);

        // Single-byte-lane write over zeroed DATA.
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
        step(1'b0, 1'b1, 1'b0, 4'b0010, 32'hFFFF12FF);
        idle(8 * SD, 1'b0);

        // we with no byte enables changes nothing.
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'hDEADBEEF);
        step(1'b0, 1'b1, 1'b1, 4'h0, 32'hDEADBEEF);
        idle(2, 1'b0);

        // BLANK write with junk in the upper bytes; read at addr 1.
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'hABCD12F0);
        idle(8 * SD, 1'b1);

        // Same-cycle write and read of DATA: old value then new value.
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h13579BDF);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h2468ACE0);
        idle(2, 1'b0);

        // Reset in the middle of digit 5, concurrent with a write.
        while (((m_k / SD) % 8) != 5 || (m_k % SD) != 2) idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFF);
        idle(2 * SD + 3, 1'b1);

        // Random bus traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout k=%0d", m_k);
        $fatal(1, "timeout");
    end

endmodule
